// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin owner selection for one shared SPI bus.
// Each requester runs its own SPI engine. The arbiter grants the bus for a
// whole transaction, muxes the owner's sclk/mosi/cs_n onto the shared pins,
// enforces a chip-select-high gap between owners and can revoke a grant
// that is held too long.
module spi_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int CS_GAP_CYCLES   = 4,
    parameter int MAX_HOLD_CYCLES = 0,
    parameter bit CPOL            = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [NUM_REQ-1:0]         req_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    input  logic [NUM_REQ-1:0]         req_sclk_i,
    input  logic [NUM_REQ-1:0]         req_mosi_i,
    input  logic [NUM_REQ-1:0]         req_cs_n_i,
    output logic [NUM_REQ-1:0]         req_miso_o,
    output logic                       spi_sclk_o,
    output logic                       spi_mosi_o,
    output logic                       spi_cs_n_o,
    input  logic                       spi_miso_i,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic                       busy_o,
    output logic [NUM_REQ-1:0]         timeout_o
);

    localparam int              IW       = $clog2(NUM_REQ);
    localparam logic [15:0]     MAX_HOLD = 16'(MAX_HOLD_CYCLES);
    localparam logic [7:0]      GAP_LOAD = 8'(CS_GAP_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        rr_q, rr_d;
    logic [15:0]          hold_q, hold_d;
    logic [7:0]           gap_q, gap_d;
    logic [NUM_REQ-1:0]   lock_q, lock_d;
    logic [NUM_REQ-1:0]   to_q, to_d;

    logic [NUM_REQ-1:0]   elig;
    logic [IW-1:0]        pick;
    logic [IW-1:0]        idx;
    logic                 found;
    logic [15:0]          hold_inc;
    logic                 busy;
    logic                 rel_ev;
    logic                 to_ev;

    // A locked-out requester stays ineligible until it drops req once.
    assign elig = req_i & ~lock_q;

    // Round-robin search: first eligible index at or after rr_q, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = IW'((int'(rr_q) + off) % NUM_REQ);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Hold counter saturates so a very long grant never wraps back to zero.
    assign hold_inc = (hold_q == 16'hFFFF) ? hold_q : hold_q + 16'd1;

    // Release wins over timeout: a dropped req is a normal end of transaction.
    assign rel_ev = !req_i[owner_q];
    assign to_ev  = (MAX_HOLD_CYCLES != 0) && req_i[owner_q] && (hold_inc == MAX_HOLD);

    // Next-state and registered-output logic for the IDLE/GRANT/GAP FSM.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        to_d    = '0;
        lock_d  = lock_q & req_i;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_GRANT;
                    owner_d = pick;
                    rr_d    = IW'((int'(pick) + 1) % NUM_REQ);
                    hold_d  = '0;
                end
            end
            S_GRANT: begin
                hold_d = hold_inc;
                if (rel_ev || to_ev) begin
                    if (to_ev) begin
                        to_d[owner_q]   = 1'b1;
                        lock_d[owner_q] = 1'b1;
                    end
                    // With no gap configured the next owner may be picked
                    // on the very next edge.
                    if (CS_GAP_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = GAP_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (gap_q <= 8'd1) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset drops ownership immediately with no gap.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
            lock_q  <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            lock_q  <= lock_d;
            to_q    <= to_d;
        end
    end

    assign busy      = (state_q == S_GRANT);
    assign busy_o    = busy;
    assign owner_o   = owner_q;
    assign timeout_o = to_q;

    // Owner mux: select is registered state only, so req_* -> spi_* is a
    // single mux level. With no owner the bus is parked idle.
    always_comb begin
        gnt_o      = '0;
        req_miso_o = '0;
        spi_cs_n_o = 1'b1;
        spi_sclk_o = CPOL;
        spi_mosi_o = 1'b0;
        if (busy) begin
            gnt_o[owner_q]      = 1'b1;
            req_miso_o[owner_q] = spi_miso_i;
            spi_cs_n_o          = req_cs_n_i[owner_q];
            spi_sclk_o          = req_sclk_i[owner_q];
            spi_mosi_o          = req_mosi_i[owner_q];
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed sequences, a mux vector table and a randomized
// run against a timestamp-based reference model of the arbiter.
module tb_spi_arbiter;

    localparam int NA = 3;
    localparam int GA = 4;
    localparam int MA = 100;
    localparam int NB = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT A: 3 requesters, gap 4, timeout 100, CPOL 0
    logic [NA-1:0] req_a, gnt_a, req_sclk_a, req_mosi_a, req_cs_n_a, req_miso_a, timeout_a;
    logic          spi_sclk_a, spi_mosi_a, spi_cs_n_a, spi_miso_a, busy_a;
    logic [1:0]    owner_a;

    // DUT B: 2 requesters, no gap, no timeout, CPOL 1
    logic [NB-1:0] req_b, gnt_b, req_sclk_b, req_mosi_b, req_cs_n_b, req_miso_b, timeout_b;
    logic          spi_sclk_b, spi_mosi_b, spi_cs_n_b, spi_miso_b, busy_b;
    logic [0:0]    owner_b;

    spi_arbiter #(.NUM_REQ(NA), .CS_GAP_CYCLES(GA), .MAX_HOLD_CYCLES(MA), .CPOL(1'b0)) u_a (
        .clk_i(clk), .reset_i(rst), .req_i(req_a), .gnt_o(gnt_a),
        .req_sclk_i(req_sclk_a), .req_mosi_i(req_mosi_a), .req_cs_n_i(req_cs_n_a),
        .req_miso_o(req_miso_a), .spi_sclk_o(spi_sclk_a), .spi_mosi_o(spi_mosi_a),
        .spi_cs_n_o(spi_cs_n_a), .spi_miso_i(spi_miso_a), .owner_o(owner_a),
        .busy_o(busy_a), .timeout_o(timeout_a));

    spi_arbiter #(.NUM_REQ(NB), .CS_GAP_CYCLES(0), .MAX_HOLD_CYCLES(0), .CPOL(1'b1)) u_b (
        .clk_i(clk), .reset_i(rst), .req_i(req_b), .gnt_o(gnt_b),
        .req_sclk_i(req_sclk_b), .req_mosi_i(req_mosi_b), .req_cs_n_i(req_cs_n_b),
        .req_miso_o(req_miso_b), .spi_sclk_o(spi_sclk_b), .spi_mosi_o(spi_mosi_b),
        .spi_cs_n_o(spi_cs_n_b), .spi_miso_i(spi_miso_b), .owner_o(owner_b),
        .busy_o(busy_b), .timeout_o(timeout_b));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Mux/MISO vectors with owner 1: inputs and expected {sclk,mosi,cs_n,req_miso}
    typedef struct {
        logic [2:0] sclk;
        logic [2:0] mosi;
        logic [2:0] csn;
        logic       miso;
        logic [5:0] exp;
    } vec_t;
    vec_t tbl [5];

    // Reference model: absolute edge timestamps instead of counters.
    int            m_owner, m_gstart, m_next_ok, m_rr, m_n;
    logic [NA-1:0] m_lock, m_to;

    task automatic model_step(input logic [NA-1:0] r);
        m_to = '0;
        for (int i = 0; i < NA; i++) if (!r[i]) m_lock[i] = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner   = -1;
                m_next_ok = m_n + GA + 1;
            end else if (m_n - m_gstart == MA) begin
                m_to[m_owner]   = 1'b1;
                m_lock[m_owner] = 1'b1;
                m_owner         = -1;
                m_next_ok       = m_n + GA + 1;
            end
        end else if (m_n >= m_next_ok) begin
            for (int off = 0; off < NA; off++) begin
                int i;
                i = (m_rr + off) % NA;
                if (m_owner < 0 && r[i] && !m_lock[i]) begin
                    m_owner  = i;
                    m_gstart = m_n;
                    m_rr     = (i + 1) % NA;
                end
            end
        end
        m_n++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int zeros, waited;
        logic [1:0] mo;
        logic [2:0] eg, rm;
        logic [5:0] eb;

        tbl[0] = '{3'b010, 3'b000, 3'b101, 1'b1, 6'b100010};
        tbl[1] = '{3'b101, 3'b010, 3'b010, 1'b0, 6'b011000};
        tbl[2] = '{3'b111, 3'b101, 3'b000, 1'b1, 6'b100010};
        tbl[3] = '{3'b000, 3'b111, 3'b111, 1'b1, 6'b011010};
        tbl[4] = '{3'b010, 3'b010, 3'b101, 1'b0, 6'b110000};

        req_a = '0; req_sclk_a = '0; req_mosi_a = '0; req_cs_n_a = '1; spi_miso_a = 1'b0;
        req_b = '0; req_sclk_b = '0; req_mosi_b = '0; req_cs_n_b = '1; spi_miso_b = 1'b0;

        // Reset state
        #12;
        chk("rst_a", 32'({gnt_a, timeout_a, busy_a, owner_a, spi_cs_n_a, spi_sclk_a, spi_mosi_a, req_miso_a}),
            32'({3'b000, 3'b000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b000}));
        chk("rst_b", 32'({gnt_b, busy_b, spi_cs_n_b, spi_sclk_b, spi_mosi_b, req_miso_b}),
            32'({2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00}));
        tick();
        rst = 1'b0;

        // Single requester
        ticks(9);
        req_a = 3'b001;
        tick();
        chk("single_gnt", 32'({busy_a, gnt_a, owner_a}), 32'({1'b1, 3'b001, 2'd0}));
        req_cs_n_a[0] = 1'b0; req_sclk_a[0] = 1'b1; req_mosi_a[0] = 1'b1; spi_miso_a = 1'b1;
        #1;
        chk("single_bus", 32'({req_miso_a, spi_sclk_a, spi_mosi_a, spi_cs_n_a}), 32'({3'b001, 1'b1, 1'b1, 1'b0}));
        ticks(28);
        chk("single_hold", 32'(gnt_a), 32'd1);
        req_a[0] = 1'b0;
        tick();
        chk("single_rel", 32'({busy_a, gnt_a}), 32'd0);
        chk("single_idle_bus", 32'({req_miso_a, spi_sclk_a, spi_mosi_a, spi_cs_n_a}), 32'({3'b000, 1'b0, 1'b0, 1'b1}));
        req_cs_n_a = '1; req_sclk_a = '0; req_mosi_a = '0; spi_miso_a = 1'b0;

        // Gap enforcement: req[1] pending while 0 owns, then 0 releases
        ticks(6);
        req_a = 3'b001;
        tick();
        chk("gap_first", 32'(gnt_a), 32'd1);
        req_a[1] = 1'b1;
        ticks(5);
        chk("gap_pending", 32'(gnt_a), 32'd1);
        req_a[0] = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("gap_gnt", 32'(gnt_a), (j == 5) ? 32'd2 : 32'd0);
            if (j < 5) chk("gap_csn", 32'(spi_cs_n_a), 32'd1);
        end

        // Mux and MISO isolation with owner 1
        for (int r = 0; r < 5; r++) begin
            req_sclk_a = tbl[r].sclk; req_mosi_a = tbl[r].mosi;
            req_cs_n_a = tbl[r].csn;  spi_miso_a = tbl[r].miso;
            #1;
            chk($sformatf("mux_row%0d", r),
                32'({spi_sclk_a, spi_mosi_a, spi_cs_n_a, req_miso_a}), 32'(tbl[r].exp));
        end
        req_cs_n_a = '1; req_sclk_a = '0; req_mosi_a = '0; spi_miso_a = 1'b1;
        req_a = '0;
        tick();
        chk("miso_idle", 32'({gnt_a, req_miso_a}), 32'd0);
        spi_miso_a = 1'b0;

        // Timeout: req[0] stuck high, req[1] waiting
        ticks(6);
        req_a = 3'b001;
        tick();
        chk("to_gnt", 32'(gnt_a), 32'd1);
        req_a[1] = 1'b1;
        ticks(99);
        chk("to_before", 32'({gnt_a, timeout_a}), 32'({3'b001, 3'b000}));
        tick();
        chk("to_edge", 32'({gnt_a, timeout_a}), 32'({3'b000, 3'b001}));
        tick();
        chk("to_pulse_end", 32'({gnt_a, timeout_a}), 32'd0);
        ticks(3);
        chk("to_gap", 32'(gnt_a), 32'd0);
        tick();
        chk("to_next", 32'(gnt_a), 32'd2);
        req_a[1] = 1'b0;
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("lockout", 32'(gnt_a), 32'd0);
        end
        req_a[0] = 1'b0;
        tick();
        req_a[0] = 1'b1;
        tick();
        chk("lock_clear", 32'(gnt_a), 32'd1);

        // Async reset mid-grant
        req_cs_n_a[0] = 1'b0;
        #1;
        chk("ar_pre_csn", 32'(spi_cs_n_a), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_drop", 32'({gnt_a, busy_a, spi_cs_n_a}), 32'({3'b000, 1'b0, 1'b1}));
        req_a = 3'b011;
        #2;
        rst = 1'b0;
        tick();
        chk("ar_rr0", 32'(gnt_a), 32'd1);
        req_cs_n_a = '1;

        // Round-robin fairness: all high, each owner releases after 8 cycles
        req_a = 3'b111;
        for (int g = 0; g < 6; g++) begin
            zeros = 0; waited = 0;
            while (!busy_a && waited < 20) begin
                if (spi_cs_n_a) zeros++;
                tick();
                waited++;
            end
            chk("rr_busy", 32'(busy_a), 32'd1);
            chk("rr_order", 32'(owner_a), 32'(g % NA));
            if (g > 0) chk("rr_gap", 32'(zeros), 32'd5);
            ticks(8);
            req_a[g % NA] = 1'b0;
            tick();
            req_a[g % NA] = 1'b1;
        end
        req_a = '0;
        ticks(8);

        // Zero gap, no timeout, CPOL 1
        req_b = 2'b01;
        tick();
        chk("b_gnt0", 32'(gnt_b), 32'd1);
        req_b = 2'b11;
        ticks(200);
        chk("b_no_timeout", 32'({gnt_b, timeout_b}), 32'({2'b01, 2'b00}));
        req_b = 2'b10;
        tick();
        chk("b_rel", 32'({gnt_b, spi_sclk_b, spi_cs_n_b}), 32'({2'b00, 1'b1, 1'b1}));
        tick();
        chk("b_gnt1", 32'(gnt_b), 32'd2);
        req_b = '0;
        tick();
        chk("b_idle", 32'(gnt_b), 32'd0);

        // Randomized run against the reference model
        rst = 1'b1;
        req_a = '0;
        ticks(2);
        rst = 1'b0;
        m_owner = -1; m_gstart = 0; m_next_ok = 0; m_rr = 0; m_n = 0;
        m_lock = '0; m_to = '0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            model_step(req_a);
            #1;
            mo = 2'(m_owner);
            eg = (m_owner >= 0) ? (3'b001 << mo) : 3'b000;
            if (m_owner >= 0) begin
                rm = 3'(spi_miso_a) << mo;
                eb = {rm, req_sclk_a[mo], req_mosi_a[mo], req_cs_n_a[mo]};
            end else begin
                eb = {3'b000, 1'b0, 1'b0, 1'b1};
            end
            chk("rand_gnt", 32'({busy_a, gnt_a}), 32'({m_owner >= 0, eg}));
            chk("rand_timeout", 32'(timeout_a), 32'(m_to));
            chk("rand_bus", 32'({req_miso_a, spi_sclk_a, spi_mosi_a, spi_cs_n_a}), 32'(eb));
            if (m_owner >= 0) chk("rand_owner", 32'(owner_a), 32'(mo));
            for (int i = 0; i < NA; i++) begin
                if (req_a[i]) begin
                    if ($urandom_range(0, 59) == 0) req_a[i] = 1'b0;
                end else if ($urandom_range(0, 5) == 0) begin
                    req_a[i] = 1'b1;
                end
            end
            req_sclk_a = 3'($urandom);
            req_mosi_a = 3'($urandom);
            req_cs_n_a = 3'($urandom);
            spi_miso_a = 1'($urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
